// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits, optional parity,
// one or two stop bits. Words are taken through a valid/ready handshake.
module uart_tx_param #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              tick
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be 2 or more");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_bad_lsb_first
    $error("uart_tx_param: LSB_FIRST must be 0 or 1");
  end

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [3:0]        bit_r, bit_s;
  logic [DATA_W-1:0] shreg_r, shreg_s;
  logic              par_r, par_s;
  logic              cnt_end_s, done_s, tx_s, tick_s;
  logic              tx_r, busy_r, ready_r, done_r, tick_r;

  // Odd mode inverts the XOR so data plus parity carries an odd count of ones.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d);
    logic p_s;
    p_s = ^d;
    if (PARITY == 1) parity_bit = ~p_s;
    else             parity_bit = p_s;
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] d);
    if (LSB_FIRST != 0) shift_word = {1'b0, d[DATA_W-1:1]};
    else                shift_word = {d[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic out_bit(input logic [DATA_W-1:0] d);
    if (LSB_FIRST != 0) out_bit = d[0];
    else                out_bit = d[DATA_W-1];
  endfunction

  // Next-state, baud/bit counters and the registered value of each output.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    shreg_s   = shreg_r;
    par_s     = par_r;
    done_s    = 1'b0;
    cnt_end_s = (cnt_r == CNT_LAST);

    if (state_r == S_IDLE) cnt_s = '0;
    else if (cnt_end_s)    cnt_s = '0;
    else                   cnt_s = cnt_r + CW'(1);

    case (state_r)
      S_IDLE: begin
        if (tx_valid) begin
          state_s = S_START;
          shreg_s = tx_data;
          par_s   = parity_bit(tx_data);
          bit_s   = 4'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_end_s) begin
          state_s = S_DATA;
          bit_s   = 4'd0;
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (cnt_end_s) begin
          shreg_s = shift_word(shreg_r);
          if (bit_r == DATA_LAST) begin
            bit_s   = 4'd0;
            state_s = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_PAR: begin
        if (cnt_end_s) begin
          state_s = S_STOP;
          bit_s   = 4'd0;
        end else begin
          state_s = S_PAR;
        end
      end
      S_STOP: begin
        if (cnt_end_s) begin
          if (bit_r == STOP_LAST) begin
            state_s = S_IDLE;
            bit_s   = 4'd0;
            done_s  = 1'b1;
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      default: state_s = S_IDLE;
    endcase

    case (state_s)
      S_IDLE:  tx_s = 1'b1;
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = out_bit(shreg_s);
      S_PAR:   tx_s = par_s;
      S_STOP:  tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase

    tick_s = (state_s != S_IDLE) && (cnt_s == CNT_LAST);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      bit_r   <= 4'd0;
      shreg_r <= '0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != S_IDLE);
      ready_r <= (state_s == S_IDLE);
      done_r  <= done_s;
      tick_r  <= tick_s;
    end
  end

  assign tx       = tx_r;
  assign busy     = busy_r;
  assign tx_ready = ready_r;
  assign done     = done_r;
  assign tick     = tick_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: five parameter sets, fixed vectors,
// back-to-back and reset corner cases, and random words against a frame model.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] data_r [5];
  logic [4:0] valid_r;
  logic [4:0] tx_w, busy_w, ready_w, done_w, tick_w;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Index: 0 default/CLK_DIV=4, 1 even, 2 odd+2stop, 3 MSB first, 4 all defaults
  int cfg_cd  [5] = '{4, 4, 2, 3, 16};
  int cfg_dw  [5] = '{8, 8, 7, 8, 8};
  int cfg_par [5] = '{0, 2, 1, 0, 0};
  int cfg_stp [5] = '{1, 1, 2, 1, 1};
  int cfg_lsb [5] = '{1, 1, 1, 0, 1};

  typedef struct {
    int         k;
    logic [8:0] word;
    logic [8:0] late;
    string      bits;
  } vec_t;
  vec_t vecs [5];

  uart_tx_param #(.CLK_DIV(4)) u_def (
    .clk(clk), .reset(reset), .tx_data(data_r[0][7:0]), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .tick(tick_w[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .tx_data(data_r[1][7:0]), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .tick(tick_w[1]));
  uart_tx_param #(.CLK_DIV(2), .DATA_W(7), .PARITY(1), .STOP_BITS(2)) u_odd (
    .clk(clk), .reset(reset), .tx_data(data_r[2][6:0]), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .tick(tick_w[2]));
  uart_tx_param #(.CLK_DIV(3), .DATA_W(8), .PARITY(0), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .tx_data(data_r[3][7:0]), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]), .tick(tick_w[3]));
  uart_tx_param u_full (
    .clk(clk), .reset(reset), .tx_data(data_r[4][7:0]), .tx_valid(valid_r[4]),
    .tx_ready(ready_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]), .tick(tick_w[4]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // {tx, busy, tx_ready, done, tick}
  function automatic int status(input int k);
    return int'({tx_w[k], busy_w[k], ready_w[k], done_w[k], tick_w[k]});
  endfunction

  // Reference frame as a string of line levels, one character per bit period.
  function automatic string build_bits(input int k, input logic [8:0] w);
    string s;
    int ones;
    int idx;
    s = "0";
    ones = 0;
    for (int i = 0; i < cfg_dw[k]; i++) begin
      idx = (cfg_lsb[k] == 1) ? i : cfg_dw[k] - 1 - i;
      if (w[idx]) s = {s, "1"};
      else        s = {s, "0"};
      if (w[i]) ones++;
    end
    if (cfg_par[k] == 1) begin
      if (ones % 2 == 0) s = {s, "1"};
      else               s = {s, "0"};
    end else if (cfg_par[k] == 2) begin
      if (ones % 2 == 1) s = {s, "1"};
      else               s = {s, "0"};
    end
    for (int i = 0; i < cfg_stp[k]; i++) s = {s, "1"};
    return s;
  endfunction

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!ready_w[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_wait k%0d", k), int'(ready_w[k]), 1);
  endtask

  // Present a word at a negedge; returns just after the accepting edge E0.
  task automatic start(input int k, input logic [8:0] w);
    @(negedge clk);
    wait_ready(k);
    data_r[k]  = w;
    valid_r[k] = 1'b1;
    @(posedge clk);
  endtask

  // Checks every cycle of a frame starting at E0 and the done cycle after it.
  task automatic run_frame(input int k, input string bits, input logic [8:0] late,
                           input bit keep, input bit poke, output int done_cyc);
    int cd;
    int f;
    int exp;
    byte ch;
    cd = cfg_cd[k];
    f  = cd * bits.len();
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      ch  = bits.getc(c / cd);
      exp = ((ch == 8'h31) ? 16 : 0) + 8 + (((c % cd) == cd - 1) ? 1 : 0);
      chk($sformatf("frame k%0d cycle %0d", k, c), status(k), exp);
      if (c == 0) data_r[k] = late;
      if (keep)                  valid_r[k] = 1'b1;
      else if (poke && c < f - 1) valid_r[k] = 1'($urandom_range(1, 0));
      else                       valid_r[k] = 1'b0;
    end
    @(negedge clk);
    done_cyc = cyc;
    chk($sformatf("done_cycle k%0d", k), status(k), 22);
    if (!keep) begin
      @(negedge clk);
      chk($sformatf("done_once k%0d", k), status(k), 20);
    end
  endtask

  initial begin
    int d1;
    int d2;
    logic [8:0] w;

    vecs[0] = '{3, 9'h081, 9'h0FF, "0100000011"};
    vecs[1] = '{1, 9'h0A5, 9'h05A, "01010010101"};
    vecs[2] = '{2, 9'h000, 9'h07F, "00000000111"};
    vecs[3] = '{0, 9'h055, 9'h00F, "0101010101"};
    vecs[4] = '{0, 9'h00F, 9'h000, "0111100001"};

    for (int k = 0; k < 5; k++) data_r[k] = 9'h000;
    valid_r = 5'b00000;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) chk($sformatf("reset_state k%0d", k), status(k), 20);
    reset = 1'b0;

    // Fixed vectors: MSB first, even parity, odd parity with two stop bits.
    for (int i = 0; i < 3; i++) begin
      start(vecs[i].k, vecs[i].word);
      run_frame(vecs[i].k, vecs[i].bits, vecs[i].late, 1'b0, 1'b1, d1);
    end

    // Back-to-back: valid held high, second word waiting during the first frame.
    start(0, vecs[3].word);
    run_frame(0, vecs[3].bits, vecs[3].late, 1'b1, 1'b0, d1);
    @(posedge clk);
    run_frame(0, vecs[4].bits, vecs[4].late, 1'b0, 1'b0, d2);
    chk("b2b_done_spacing", d2 - d1, 41);

    // Reset in the middle of a data bit on the default configuration.
    start(4, 9'h0C3);
    @(negedge clk);
    valid_r[4] = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_frame_busy", int'(busy_w[4]), 1);
    #2 reset = 1'b1;
    #1 chk("reset_async", status(4), 20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", status(4), 20);
    end
    reset = 1'b0;
    w = 9'h05A;
    start(4, w);
    run_frame(4, build_bits(4, w), 9'h1FF, 1'b0, 1'b0, d1);

    // Random words on every configuration, with junk handshakes while busy.
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 6; n++) begin
        w = 9'($urandom) & 9'((1 << cfg_dw[k]) - 1);
        repeat ($urandom_range(2, 0)) @(negedge clk);
        start(k, w);
        run_frame(k, build_bits(k, w), 9'($urandom), 1'b0, 1'($urandom_range(1, 0)), d1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter: the next generation of the team's fixed 8-bit FSM transmitter. It serialises one DATA_W-bit word per frame. Each frame is a start bit, data bits (configurable order), an optional parity bit and one or two stop bits. An internal baud divisor times each bit, and words are accepted through a valid/ready handshake so back-to-back frames need no idle gap. It sits between the host-side data source and the serial line.

Parameters:
CLK_DIV, 16, clk cycles per bit period; legal range is 2 or more.
DATA_W, 8, data bits per frame; legal range is 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
LSB_FIRST, 1, bit order: 1 sends bit 0 first, 0 sends bit DATA_W-1 first.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  reset, asynchronous, active-high
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_valid  input  1  source has a word available
tx_ready  output  1  block can accept a word; equals (state==IDLE)
tx  output  1  serial line; idle level is 1
busy  output  1  high while a frame is in progress (state!=IDLE)
done  output  1  one-cycle pulse after the final stop bit completes
tick  output  1  one-cycle pulse at the end of each bit period

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE, tx=1, busy=0, done=0, tick=0, tx_ready=1.
  - Baud counter, bit counter and shift register are cleared; any partial frame is abandoned.
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when PARITY=0.
- Handshake:
  - Acceptance happens at rising edge E0 where tx_valid && tx_ready.
  - At E0: tx_data is latched into the shift register; the parity bit is computed from the latched word; baud counter is cleared; state goes to START.
  - tx_valid and tx_data are ignored while busy, and changes to tx_data after E0 do not affect the frame.
- Baud counter:
  - Counts 0..CLK_DIV-1 in every non-IDLE state and is held at 0 in IDLE.
  - tick is high during the cycle the counter equals CLK_DIV-1.
  - Each bit period ends on the edge that follows a tick cycle.
- Bit timing: every bit drives tx for exactly CLK_DIV cycles.
  - START: tx=0.
  - DATA: tx = current shift-register bit. The register shifts at each bit period end, and the bit counter advances 0..DATA_W-1. After bit DATA_W-1 the state goes to PARITY or STOP.
  - PARITY: tx = parity bit.
    - Odd mode: the total number of ones across data plus parity is odd.
    - Even mode: that total is even (parity = XOR of the data bits).
  - STOP: tx=1 for STOP_BITS bit periods.
- Frame timing: frame length F = CLK_DIV*(1 + DATA_W + (PARITY!=0) + STOP_BITS) clocks. tx is 0 from E0 through E0+CLK_DIV.
- End of frame, at edge E0+F:
  - State returns to IDLE.
  - done is registered high for exactly the following cycle.
  - tx_ready is high in that same cycle.
- Back-to-back: if tx_valid is high in the cycle done is high, the next word is accepted at edge E0+F+1. The stop level lasts exactly STOP_BITS*CLK_DIV+1 cycles, and no extra idle period is inserted.
- tx is registered with no glitches. It changes only on clk edges or reset assertion.
- Illegal parameter values must stop elaboration with an error; they must not silently clamp.

Test Plan:
- Reset mid-frame (default parameters): assert reset while in DATA state → tx=1, busy=0 and tx_ready=1 immediately, done never pulses; the next accepted word produces a clean, complete frame.
- Even parity (CLK_DIV=4, DATA_W=8, PARITY=2, STOP_BITS=1): send 0xA5 → tx bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles; done high in cycle E0+44 only; tick pulses 11 times.
- Odd parity, 2 stop bits (CLK_DIV=2, DATA_W=7, PARITY=1, STOP_BITS=2): send 7'h00 → start 0, seven 0s, parity 1, stop 1,1; F=22 cycles.
- MSB first (CLK_DIV=3, DATA_W=8, PARITY=0, LSB_FIRST=0): send 0x81 → 0,1,0,0,0,0,0,0,1,1; tx_data changed to 0xFF mid-frame has no effect.
- Back-to-back (CLK_DIV=4, defaults otherwise): hold tx_valid high with 0x55 then 0x0F → second start bit begins at E0+41; stop level lasts 5 cycles; two done pulses 41 cycles apart.
- Ignored handshake: pulse tx_valid while busy=1 → no acceptance, tx_ready stays 0, frame unchanged; the word is accepted only after returning to IDLE.
